// File: rtl/pipeexemd.sv
// Pipelined MIPS execute stage: ALU, jump-and-link result and an iterative
// multiply/divide unit whose HI/LO registers are read back through mfhi/mflo.
module pipeexemd #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [3:0]       ealuc,
   input  logic             ealuimm,
   input  logic             eshift,
   input  logic             ejal,
   input  logic [2:0]       emdop,
   input  logic [WIDTH-1:0] ea,
   input  logic [WIDTH-1:0] eb,
   input  logic [WIDTH-1:0] eimm,
   input  logic [WIDTH-1:0] epc4,
   input  logic [4:0]       ern0,
   output logic [4:0]       ern,
   output logic [WIDTH-1:0] ealu,
   output logic             estall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned H  = WIDTH / 2;
   localparam int unsigned SW = $clog2(WIDTH);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [2:0] MdMult  = 3'b001;
   localparam logic [2:0] MdMultu = 3'b010;
   localparam logic [2:0] MdDiv   = 3'b011;
   localparam logic [2:0] MdDivu  = 3'b100;
   localparam logic [2:0] MdMfhi  = 3'b101;
   localparam logic [2:0] MdMflo  = 3'b110;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             div_q, div_d;
   logic             sa_q, sa_d, sb_q, sb_d;
   logic [WIDTH-1:0] ma_q, ma_d, mb_q, mb_d;
   logic [WIDTH-1:0] r_q, r_d, q_q, q_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

   logic [WIDTH-1:0] alu_a, alu_b, alu_r;
   logic [SW-1:0]    shamt;

   // ALU: op[1:0] picks the group, op[2] the variant, op[3] arithmetic right shift
   assign alu_a = eshift  ? eimm : ea;
   assign alu_b = ealuimm ? eimm : eb;
   assign shamt = alu_a[SW-1:0];

   always_comb begin
      alu_r = '0;
      unique case (ealuc[1:0])
         2'b00: alu_r = ealuc[2] ? alu_a - alu_b : alu_a + alu_b;
         2'b01: alu_r = ealuc[2] ? alu_a | alu_b : alu_a & alu_b;
         2'b10: alu_r = ealuc[2] ? {alu_b[H-1:0], {H{1'b0}}} : alu_a ^ alu_b;
         default: begin
            if (!ealuc[2])     alu_r = alu_b << shamt;
            else if (ealuc[3]) alu_r = WIDTH'($signed(alu_b) >>> shamt);
            else               alu_r = alu_b >> shamt;
         end
      endcase
   end

   assign ern = ern0 | {5{ejal}};

   always_comb begin
      if (ejal)                  ealu = epc4 + WIDTH'(4);
      else if (emdop == MdMfhi)  ealu = hi_q;
      else if (emdop == MdMflo)  ealu = lo_q;
      else                       ealu = alu_r;
   end

   assign hi = hi_q;
   assign lo = lo_q;

   // One iteration of shift-add multiply ({r,q} shifts right) or restoring divide
   logic [WIDTH:0]   mul_sum, div_sh;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff, mr, mq, dr, dq;

   assign mul_sum  = {1'b0, r_q} + (q_q[0] ? {1'b0, ma_q} : '0);
   assign mr       = mul_sum[WIDTH:1];
   assign mq       = {mul_sum[0], q_q[WIDTH-1:1]};
   assign div_sh   = {r_q, q_q[WIDTH-1]};
   assign div_ge   = div_sh >= {1'b0, mb_q};
   assign div_diff = div_sh[WIDTH-1:0] - mb_q;
   assign dr       = div_ge ? div_diff : div_sh[WIDTH-1:0];
   assign dq       = {q_q[WIDTH-2:0], div_ge};

   logic             md_start, md_sgn;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] qv, rv;

   assign md_start = emdop inside {MdMult, MdMultu, MdDiv, MdDivu};
   assign md_sgn   = (emdop == MdMult) || (emdop == MdDiv);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      ma_d    = ma_q;
      mb_d    = mb_q;
      r_d     = r_q;
      q_d     = q_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      estall  = 1'b0;
      prod    = '0;
      qv      = '0;
      rv      = '0;
      unique case (state_q)
         StIdle: begin
            if (md_start) begin
               estall  = 1'b1;
               state_d = StBusy;
               cnt_d   = CW'(WIDTH);
               div_d   = (emdop == MdDiv) || (emdop == MdDivu);
               sa_d    = md_sgn & ea[WIDTH-1];
               sb_d    = md_sgn & eb[WIDTH-1];
               ma_d    = sa_d ? -ea : ea;
               mb_d    = sb_d ? -eb : eb;
               r_d     = '0;
               q_d     = div_d ? ma_d : mb_d;
            end
         end
         StBusy: begin
            estall = 1'b1;
            cnt_d  = cnt_q - CW'(1);
            r_d    = div_q ? dr : mr;
            q_d    = div_q ? dq : mq;
            if (cnt_q == CW'(1)) begin
               state_d = StDone;
               if (!div_q) begin
                  prod = {mr, mq};
                  if (sa_q ^ sb_q) prod = -prod;
                  hi_d = prod[2*WIDTH-1:WIDTH];
                  lo_d = prod[WIDTH-1:0];
               end else if (mb_q == '0) begin
                  lo_d = '1;
                  hi_d = sa_q ? -ma_q : ma_q;
               end else begin
                  qv   = (sa_q ^ sb_q) ? -dq : dq;
                  rv   = sa_q ? -dr : dr;
                  lo_d = qv;
                  hi_d = rv;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         ma_q    <= '0;
         mb_q    <= '0;
         r_q     <= '0;
         q_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         r_q     <= r_d;
         q_q     <= q_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: tb/tb_pipeexemd.sv
// Directed bench for pipeexemd: ALU/jal results, MDU ops with stall timing,
// back-to-back ops and reset abort, at WIDTH=32 and WIDTH=8.
module tb_pipeexemd;

   logic        clock = 1'b0;
   logic        resetn;
   logic [3:0]  ealuc;
   logic        ealuimm, eshift, ejal;
   logic [2:0]  emdop;
   logic [31:0] ea, eb, eimm, epc4;
   logic [4:0]  ern0, ern;
   logic [31:0] ealu, hi, lo;
   logic        estall;

   logic [3:0]  ealuc8;
   logic        ealuimm8, eshift8, ejal8;
   logic [2:0]  emdop8;
   logic [7:0]  ea8, eb8, eimm8, epc48;
   logic [4:0]  ern08, ern8;
   logic [7:0]  ealu8, hi8, lo8;
   logic        estall8;

   int nvec = 0;
   int nerr = 0;

   always #5 clock = ~clock;

   pipeexemd #(.WIDTH(32)) dut (
      .clock(clock), .resetn(resetn), .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift),
      .ejal(ejal), .emdop(emdop), .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .ern0(ern0),
      .ern(ern), .ealu(ealu), .estall(estall), .hi(hi), .lo(lo)
   );

   pipeexemd #(.WIDTH(8)) dut8 (
      .clock(clock), .resetn(resetn), .ealuc(ealuc8), .ealuimm(ealuimm8), .eshift(eshift8),
      .ejal(ejal8), .emdop(emdop8), .ea(ea8), .eb(eb8), .eimm(eimm8), .epc4(epc48),
      .ern0(ern08), .ern(ern8), .ealu(ealu8), .estall(estall8), .hi(hi8), .lo(lo8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic alu_vec(input string tag, input logic [3:0] op, input logic aimm,
                          input logic sh, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [31:0] exp);
      ealuc = op; ealuimm = aimm; eshift = sh; ea = a; eb = b; eimm = imm;
      #1;
      check(tag, ealu, exp);
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic mdu_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
      logic [31:0] hi0;
      int n;
      hi0 = hi;
      emdop = op; ea = a; eb = b;
      #1;
      n = 0;
      while (estall && n < 100) begin
         n++;
         if (n == 16) check({tag, "_hold"}, hi, hi0);
         @(posedge clock); #1;
      end
      check({tag, "_stall"}, n, 33);
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
      @(posedge clock); #1;
      emdop = 3'b000;
   endtask

   task automatic mdu8(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp_hi, input logic [7:0] exp_lo);
      int n;
      emdop8 = op; ea8 = a; eb8 = b;
      #1;
      n = 0;
      while (estall8 && n < 50) begin
         n++;
         @(posedge clock); #1;
      end
      check({tag, "_stall"}, n, 9);
      check({tag, "_hi"}, hi8, exp_hi);
      check({tag, "_lo"}, lo8, exp_lo);
      @(posedge clock); #1;
      emdop8 = 3'b000;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0;
      ealuc = 4'h0; ealuimm = 1'b0; eshift = 1'b0; ejal = 1'b0; emdop = 3'b000;
      ea = '0; eb = '0; eimm = '0; epc4 = '0; ern0 = '0;
      ealuc8 = 4'h0; ealuimm8 = 1'b0; eshift8 = 1'b0; ejal8 = 1'b0; emdop8 = 3'b000;
      ea8 = '0; eb8 = '0; eimm8 = '0; epc48 = '0; ern08 = '0;

      repeat (2) @(posedge clock);
      #1;
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_stall", estall, 0);
      emdop = 3'b101; #1;
      check("rst_mfhi", ealu, 0);
      emdop = 3'b001; #1;
      check("rst_stall_op", estall, 1);
      emdop = 3'b000; #1;
      resetn = 1'b1;
      @(posedge clock); #1;

      alu_vec("add",  4'b0000, 1'b0, 1'b0, 32'd5, 32'd7, 32'h0, 32'd12);
      check("add_stall", estall, 0);
      alu_vec("sub",  4'b0100, 1'b0, 1'b0, 32'd5, 32'd7, 32'h0, 32'hFFFF_FFFE);
      alu_vec("and",  4'b0001, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 32'h00F0_1200);
      alu_vec("or",   4'b0101, 1'b0, 1'b0, 32'hF000_0001, 32'h0000_0F00, 32'h0, 32'hF000_0F01);
      alu_vec("xor",  4'b0010, 1'b0, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0, 32'hF0F0_0F0F);
      alu_vec("addi", 4'b0000, 1'b1, 1'b0, 32'd5, 32'd99, 32'h10, 32'h15);
      alu_vec("lui",  4'b0110, 1'b1, 1'b0, 32'd0, 32'd0, 32'h1234, 32'h1234_0000);
      alu_vec("sll",  4'b0011, 1'b0, 1'b1, 32'd0, 32'd1, 32'd4, 32'd16);
      alu_vec("srl",  4'b0111, 1'b0, 1'b1, 32'd0, 32'h8000_0000, 32'd4, 32'h0800_0000);
      alu_vec("sra",  4'b1111, 1'b0, 1'b1, 32'd0, 32'h8000_0000, 32'd4, 32'hF800_0000);
      ealuimm = 1'b0; eshift = 1'b0; ealuc = 4'h0;

      ern0 = 5'd5; #1;
      check("ern_plain", ern, 5);
      ejal = 1'b1; epc4 = 32'h100; ern0 = 5'd0; #1;
      check("jal_ealu", ealu, 32'h104);
      check("jal_ern", ern, 31);
      ejal = 1'b0;
      emdop = 3'b111; #1;
      check("rsvd_stall", estall, 0);
      emdop = 3'b000;
      @(posedge clock); #1;

      mdu_op("mult", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      emdop = 3'b110; #1;
      check("mflo", ealu, 32'hFFFF_FFFA);
      check("mflo_stall", estall, 0);
      emdop = 3'b101; #1;
      check("mfhi", ealu, 32'hFFFF_FFFF);
      emdop = 3'b000;
      @(posedge clock); #1;

      mdu_op("div",  3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      mdu_op("divu0", 3'b100, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
      mdu_op("div0", 3'b011, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
      mdu_op("divmin", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      mdu_op("multu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
      mdu_op("divu", 3'b100, 32'd100, 32'd7, 32'd2, 32'd14);

      mdu8("mult8", 3'b001, 8'hFE, 8'd3, 8'hFF, 8'hFA);
      mdu8("divmin8", 3'b011, 8'h80, 8'hFF, 8'h00, 8'h80);
      mdu8("mult8b", 3'b010, 8'd20, 8'd30, 8'h02, 8'h58);

      // Abort both units mid-BUSY; hi/lo hold nonzero results beforehand.
      emdop = 3'b001; ea = 32'd1000; eb = 32'd1000;
      emdop8 = 3'b010; ea8 = 8'd7; eb8 = 8'd9;
      repeat (4) @(posedge clock);
      #1;
      check("abort_busy", estall, 1);
      check("abort_busy8", estall8, 1);
      emdop = 3'b000; emdop8 = 3'b000; resetn = 1'b0;
      #1;
      check("abort_stall", estall, 0);
      check("abort_hi", hi, 0);
      check("abort_lo", lo, 0);
      check("abort_stall8", estall8, 0);
      check("abort_hi8", hi8, 0);
      check("abort_lo8", lo8, 0);
      @(posedge clock); #1;
      resetn = 1'b1;
      repeat (40) @(posedge clock);
      #1;
      check("post_lo", lo, 0);
      check("post_stall", estall, 0);
      check("post_lo8", lo8, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
